// File: rtl/mem_arbiter_if.sv
// Bundles the fetch/data requester handshakes and the memory pins seen by mem_arbiter.
// The arbiter uses the slave modport; requesters and the memory sit on the master side.
interface mem_arbiter_if;
  logic        i_req;
  logic [31:0] i_addr;
  logic [31:0] i_rdata;
  logic        i_done;
  logic        i_err;

  logic        d_req;
  logic        d_we;
  logic [31:0] d_addr;
  logic [31:0] d_wdata;
  logic [31:0] d_rdata;
  logic        d_done;
  logic        d_err;

  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_we;
  logic [31:0] mem_RD;

  logic        busy;

  modport slave (
    input  i_req, i_addr,
    input  d_req, d_we, d_addr, d_wdata,
    input  mem_RD,
    output i_rdata, i_done, i_err,
    output d_rdata, d_done, d_err,
    output mem_A, mem_WD, mem_we,
    output busy
  );

  modport master (
    output i_req, i_addr,
    output d_req, d_we, d_addr, d_wdata,
    output mem_RD,
    input  i_rdata, i_done, i_err,
    input  d_rdata, d_done, d_err,
    input  mem_A, mem_WD, mem_we,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port memory between fetch (I) and load/store (D), one transaction at a time.
// Define ARB_ROUND_ROBIN_EN for alternating tie-breaks; otherwise D always beats I.
module mem_arbiter #(
  parameter int MEM_DEPTH   = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam logic [1:0]  IDLE   = 2'd0;
  localparam logic [1:0]  ACCESS = 2'd1;
  localparam logic [1:0]  RESP   = 2'd2;

  localparam logic [3:0]  CNT_INIT    = 4'(WAIT_CYCLES - 1);
  localparam logic [29:0] DEPTH_WORDS = 30'(MEM_DEPTH);

  logic [1:0]  state;
  logic [3:0]  cnt;
  logic        owner_d;
  logic        lat_we;
  logic        lat_err;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic [31:0] i_rdata_q;
  logic [31:0] d_rdata_q;

  logic        req_any;
  logic        grant_d;
  logic [31:0] sel_addr;
  logic        sel_err;
  logic        in_access;
  logic        in_resp;

  assign req_any = bus.i_req | bus.d_req;

`ifdef ARB_ROUND_ROBIN_EN
  // last_grant_d starts at D so that the first tie after reset goes to fetch.
  logic last_grant_d;

  assign grant_d = bus.d_req & (~bus.i_req | ~last_grant_d);

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_d <= 1'b1;
    end else if (state == IDLE && req_any) begin
      last_grant_d <= grant_d;
    end
  end
`else
  assign grant_d = bus.d_req;
`endif

  assign sel_addr = grant_d ? bus.d_addr : bus.i_addr;
  assign sel_err  = (sel_addr[1:0] != 2'b00) || (sel_addr[31:2] >= DEPTH_WORDS);

  // Failed checks skip ACCESS entirely so a bad store can never touch memory.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      cnt       <= 4'd0;
      owner_d   <= 1'b0;
      lat_we    <= 1'b0;
      lat_err   <= 1'b0;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
      i_rdata_q <= 32'd0;
      d_rdata_q <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (req_any) begin
            owner_d   <= grant_d;
            lat_addr  <= sel_addr;
            lat_we    <= grant_d & bus.d_we;
            lat_wdata <= grant_d ? bus.d_wdata : 32'd0;
            lat_err   <= sel_err;
            cnt       <= CNT_INIT;
            state     <= sel_err ? RESP : ACCESS;
          end
        end
        ACCESS: begin
          if (cnt == 4'd0) begin
            if (!lat_we) begin
              if (owner_d) begin
                d_rdata_q <= bus.mem_RD;
              end else begin
                i_rdata_q <= bus.mem_RD;
              end
            end
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign in_access = (state == ACCESS);
  assign in_resp   = (state == RESP);

  // Memory pins are zeroed outside ACCESS; the write strobe fires only on the final ACCESS cycle.
  assign bus.mem_A   = in_access ? lat_addr  : 32'd0;
  assign bus.mem_WD  = in_access ? lat_wdata : 32'd0;
  assign bus.mem_we  = in_access && (cnt == 4'd0) && lat_we;

  assign bus.i_done  = in_resp && !owner_d;
  assign bus.d_done  = in_resp &&  owner_d;
  assign bus.i_err   = in_resp && !owner_d && lat_err;
  assign bus.d_err   = in_resp &&  owner_d && lat_err;
  assign bus.i_rdata = i_rdata_q;
  assign bus.d_rdata = d_rdata_q;
  assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: transaction-level timing model checked every cycle, plus literal spot checks.
// A second instance with WAIT_CYCLES=3 covers multi-cycle latency and reset during a store.
module tb_mem_arbiter;

  localparam int DEPTH = 1024;
  localparam int W     = 1;
  localparam int W3    = 3;

  logic clk = 1'b0;
  logic reset;
  logic reset3;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  mem_arbiter_if bus ();
  mem_arbiter_if bus3 ();

  mem_arbiter #(.MEM_DEPTH(DEPTH), .WAIT_CYCLES(W))  dut  (.clk(clk), .reset(reset),  .bus(bus));
  mem_arbiter #(.MEM_DEPTH(DEPTH), .WAIT_CYCLES(W3)) dut3 (.clk(clk), .reset(reset3), .bus(bus3));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory seen by the W=1 instance: asynchronous read, write on the clock edge.
  logic [31:0] ram [0:1023];
  assign bus.mem_RD = ram[bus.mem_A[11:2]];
  always @(posedge clk) if (bus.mem_we) ram[bus.mem_A[11:2]] = bus.mem_WD;

  assign bus3.mem_RD = bus3.mem_A ^ 32'h5A5A_0000;

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %b expected %b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic check_word(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Transaction model: grant cycle g, access window g+1..g+W, done at g+W+1 (g+1 on error).
  logic [31:0] ref_mem [0:1023];
  bit          model_on = 0;
  bit          t_valid = 0;
  bit          t_d, t_we, t_err;
  logic [31:0] t_addr, t_wdata, t_rdata;
  int          t_g, t_done;
  int          next_idle = 0;
  bit          m_last_d = 1;
  bit          fin_i, fin_d;

  bit          e_busy, e_acc, e_we, e_idone, e_ddone, e_ierr, e_derr;
  logic [31:0] e_A, e_WD;

  always @(negedge clk) begin
    if (model_on) begin
      e_busy = 0; e_acc = 0; e_we = 0; e_idone = 0; e_ddone = 0; e_ierr = 0; e_derr = 0;
      e_A = 32'd0; e_WD = 32'd0;
      if (t_valid) begin
        e_busy = (cyc > t_g) && (cyc <= t_done);
        e_acc  = !t_err && (cyc > t_g) && (cyc <= t_g + W);
        if (e_acc) begin
          e_A  = t_addr;
          e_WD = t_wdata;
          e_we = t_we && (cyc == t_g + W);
        end
        if (cyc == t_done) begin
          e_idone = !t_d;
          e_ddone = t_d;
          e_ierr  = !t_d && t_err;
          e_derr  = t_d && t_err;
        end
      end
      check_bit("busy", bus.busy, e_busy);
      check_bit("mem_we", bus.mem_we, e_we);
      check_word("mem_A", bus.mem_A, e_A);
      check_word("mem_WD", bus.mem_WD, e_WD);
      check_bit("i_done", bus.i_done, e_idone);
      check_bit("d_done", bus.d_done, e_ddone);
      check_bit("i_err", bus.i_err, e_ierr);
      check_bit("d_err", bus.d_err, e_derr);
      if (e_idone && !t_err) check_word("i_rdata", bus.i_rdata, t_rdata);
      if (e_ddone && !t_err && !t_we) check_word("d_rdata", bus.d_rdata, t_rdata);
      if (e_acc && cyc == t_g + W) begin
        if (t_we) ref_mem[t_addr[11:2]] = t_wdata;
        else      t_rdata = ref_mem[t_addr[11:2]];
      end
      if (e_idone) fin_i = 1;
      if (e_ddone) fin_d = 1;
    end
    if (reset) begin
      model_on  = 1;
      t_valid   = 0;
      next_idle = cyc + 1;
      m_last_d  = 1;
    end else if (model_on && cyc >= next_idle && (bus.i_req || bus.d_req)) begin
`ifdef ARB_ROUND_ROBIN_EN
      if (bus.i_req && bus.d_req) t_d = !m_last_d;
      else                        t_d = bus.d_req;
`else
      t_d = bus.d_req;
`endif
      t_addr    = t_d ? bus.d_addr : bus.i_addr;
      t_we      = t_d && bus.d_we;
      t_wdata   = t_d ? bus.d_wdata : 32'd0;
      t_err     = (t_addr[1:0] != 2'b00) || ((t_addr >> 2) >= 32'(DEPTH));
      t_g       = cyc;
      t_done    = t_err ? cyc + 1 : cyc + W + 1;
      next_idle = t_done + 1;
      t_valid   = 1;
      m_last_d  = t_d;
    end
  end

  // Captures of the most recent completions, used by the literal checks.
  int          cap_i_cyc = -1, cap_d_cyc = -1, we_count = 0;
  logic [31:0] cap_i_rdata, cap_d_rdata, last_we_A;
  logic        cap_i_err, cap_d_err;

  always @(negedge clk) begin
    if (bus.i_done === 1'b1) begin
      cap_i_cyc = cyc; cap_i_rdata = bus.i_rdata; cap_i_err = bus.i_err;
    end
    if (bus.d_done === 1'b1) begin
      cap_d_cyc = cyc; cap_d_rdata = bus.d_rdata; cap_d_err = bus.d_err;
    end
    if (bus.mem_we === 1'b1) begin
      we_count++; last_we_A = bus.mem_A;
    end
  end

  // Holds each requested side until the model says it completed, then idles one cycle.
  task automatic apply_stimulus(input bit use_i, input logic [31:0] ia, input bit use_d,
                                input bit dwe, input logic [31:0] da, input logic [31:0] dwd,
                                output int rc);
    bit wi, wd;
    @(posedge clk); #2;
    fin_i = 0; fin_d = 0;
    bus.i_req = use_i; bus.i_addr = ia;
    bus.d_req = use_d; bus.d_we = dwe; bus.d_addr = da; bus.d_wdata = dwd;
    rc = cyc; wi = use_i; wd = use_d;
    for (int k = 0; k < 40 && (wi || wd); k++) begin
      @(posedge clk); #2;
      if (wi && fin_i) begin wi = 0; bus.i_req = 1'b0; end
      if (wd && fin_d) begin wd = 0; bus.d_req = 1'b0; end
    end
    if (wi || wd) begin
      checks++; failures++;
      $display("[TB] FAIL handshake_timeout: outstanding i=%0b d=%0b required none", wi, wd);
      bus.i_req = 1'b0; bus.d_req = 1'b0;
    end
    @(posedge clk); #2;
  endtask

  initial begin
    int rc, k3, done_k, we3_seen, done3_seen;

    for (int k = 0; k < 1024; k++) begin
      ram[k]     = 32'hC0DE_0000 | 32'(k);
      ref_mem[k] = 32'hC0DE_0000 | 32'(k);
    end
    ram[4]     = 32'h0050_0093;
    ref_mem[4] = 32'h0050_0093;

    reset = 1'b1; reset3 = 1'b1;
    bus.i_req = 0; bus.i_addr = 0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = 0; bus.d_wdata = 0;
    bus3.i_req = 0; bus3.i_addr = 0; bus3.d_req = 0; bus3.d_we = 0; bus3.d_addr = 0; bus3.d_wdata = 0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0; reset3 = 1'b0;

    $display("[TB] reset state");
    check_bit("rst_busy", bus.busy, 1'b0);
    check_bit("rst_i_done", bus.i_done, 1'b0);
    check_bit("rst_d_done", bus.d_done, 1'b0);
    check_bit("rst_mem_we", bus.mem_we, 1'b0);
    check_word("rst_mem_A", bus.mem_A, 32'd0);
    check_word("rst_mem_WD", bus.mem_WD, 32'd0);
    check_word("rst_i_rdata", bus.i_rdata, 32'd0);
    check_word("rst_d_rdata", bus.d_rdata, 32'd0);
    check_bit("rst3_busy", bus3.busy, 1'b0);

    $display("[TB] fetch 0x10");
    apply_stimulus(1, 32'h10, 0, 0, 32'h0, 32'h0, rc);
    check_word("fetch_latency", 32'(cap_i_cyc), 32'(rc + 2));
    check_word("fetch_rdata", cap_i_rdata, 32'h0050_0093);
    check_bit("fetch_err", cap_i_err, 1'b0);
    check_word("fetch_no_write", 32'(we_count), 32'd0);

    $display("[TB] store then load 0x20");
    apply_stimulus(0, 32'h0, 1, 1, 32'h20, 32'hDEAD_BEEF, rc);
    check_word("store_we_count", 32'(we_count), 32'd1);
    check_word("store_we_addr", last_we_A, 32'h20);
    check_word("store_ram8", ram[8], 32'hDEAD_BEEF);
    check_bit("store_err", cap_d_err, 1'b0);
    apply_stimulus(0, 32'h0, 1, 0, 32'h20, 32'h0, rc);
    check_word("load_rdata", cap_d_rdata, 32'hDEAD_BEEF);

    $display("[TB] simultaneous I 0x0 and D 0x40");
    apply_stimulus(1, 32'h0, 1, 0, 32'h40, 32'h0, rc);
`ifdef ARB_ROUND_ROBIN_EN
    check_word("tie_first_i", 32'(cap_i_cyc), 32'(rc + 2));
    check_word("tie_second_d", 32'(cap_d_cyc), 32'(rc + 5));
`else
    check_word("tie_first_d", 32'(cap_d_cyc), 32'(rc + 2));
    check_word("tie_second_i", 32'(cap_i_cyc), 32'(rc + 5));
`endif
    check_word("tie_i_rdata", cap_i_rdata, 32'hC0DE_0000);
    check_word("tie_d_rdata", cap_d_rdata, 32'hC0DE_0010);

    $display("[TB] misaligned store 0x22");
    apply_stimulus(0, 32'h0, 1, 1, 32'h22, 32'h1111_2222, rc);
    check_word("misal_latency", 32'(cap_d_cyc), 32'(rc + 1));
    check_bit("misal_err", cap_d_err, 1'b1);
    check_word("misal_no_write", 32'(we_count), 32'd1);
    check_word("misal_ram8", ram[8], 32'hDEAD_BEEF);

    $display("[TB] range boundary");
    apply_stimulus(0, 32'h0, 1, 0, 32'h1000, 32'h0, rc);
    check_bit("oob_err", cap_d_err, 1'b1);
    apply_stimulus(0, 32'h0, 1, 0, 32'hFFC, 32'h0, rc);
    check_bit("last_word_err", cap_d_err, 1'b0);
    check_word("last_word_rdata", cap_d_rdata, 32'hC0DE_03FF);
    apply_stimulus(1, 32'h6, 0, 0, 32'h0, 32'h0, rc);
    check_bit("fetch_misal_err", cap_i_err, 1'b1);
    check_word("fetch_misal_latency", 32'(cap_i_cyc), 32'(rc + 1));

    $display("[TB] WAIT_CYCLES=3 load latency");
    @(posedge clk); #2;
    bus3.d_req = 1; bus3.d_we = 0; bus3.d_addr = 32'h40;
    done_k = -1;
    for (int k = 1; k <= 8; k++) begin
      @(posedge clk); #2;
      if (done_k < 0 && bus3.d_done === 1'b1) begin
        done_k = k;
        check_word("w3_rdata", bus3.d_rdata, 32'h5A5A_0040);
        check_bit("w3_err", bus3.d_err, 1'b0);
        bus3.d_req = 0;
      end
    end
    bus3.d_req = 0;
    check_word("w3_latency", 32'(done_k), 32'd4);

    $display("[TB] WAIT_CYCLES=3 reset during store");
    @(posedge clk); #2;
    bus3.d_req = 1; bus3.d_we = 1; bus3.d_addr = 32'h30; bus3.d_wdata = 32'h1234_5678;
    we3_seen = 0; done3_seen = 0;
    if (bus3.mem_we === 1'b1) we3_seen++;
    for (k3 = 1; k3 <= 8; k3++) begin
      @(posedge clk); #2;
      if (bus3.mem_we === 1'b1) we3_seen++;
      if (k3 == 1) check_bit("w3_busy_access", bus3.busy, 1'b1);
      if (k3 == 2) reset3 = 1'b1;
      if (k3 == 3) begin
        reset3 = 1'b0; bus3.d_req = 0;
        check_bit("w3_busy_after_reset", bus3.busy, 1'b0);
      end
      if (k3 >= 3 && bus3.d_done === 1'b1) done3_seen++;
    end
    check_word("w3_no_write", 32'(we3_seen), 32'd0);
    check_word("w3_no_done", 32'(done3_seen), 32'd0);
    check_bit("w3_idle_end", bus3.busy, 1'b0);

    repeat (2) @(posedge clk);
    #2;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
